// File: rtl/crc16_word_packer.sv
// crc16_word_packer: packs a valid/ready byte stream into 64-bit words, MSB-first,
// for a downstream CRC-16 engine. Each frame is BLOCK_BYTES data bytes followed by
// two received CRC bytes. At frame start the packer pulses initialize. It pulses
// crc16_enable once per packed word. After the trailing CRC bytes are captured it
// pulses crc_valid.
module crc16_word_packer #(
  parameter int unsigned BLOCK_BYTES = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        initialize,
  output logic        crc16_enable,
  output logic [63:0] crc16_DI,
  output logic [15:0] crc16_I,
  output logic        crc_valid,
  output logic        busy,
  output logic        frame_err
);

  localparam int unsigned WORDS = BLOCK_BYTES / 8;
  localparam int unsigned WCW   = $clog2(WORDS + 1);

  localparam logic [WCW-1:0] LAST_WORD = WCW'(WORDS - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] INIT   = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] CRC_HI = 3'd3;
  localparam logic [2:0] CRC_LO = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  logic [2:0]     state_q, state_d;
  // Only the first seven bytes of a word need storing; the eighth goes straight
  // into the output word.
  logic [55:0]    sr_q, sr_d;
  logic [2:0]     lane_q, lane_d;
  logic [WCW-1:0] word_q, word_d;
  logic [63:0]    di_q, di_d;
  logic           en_q, en_d;
  logic           init_q, init_d;
  logic [15:0]    crci_q, crci_d;
  logic           crcv_q, crcv_d;
  logic           ferr_q, ferr_d;

  logic           ready;
  logic           xfer;

  // Handshake: decoded from registered state so byte_ready has no input path.
  always_comb begin
    ready = (state_q == DATA) || (state_q == CRC_HI) || (state_q == CRC_LO);
    xfer  = ready && byte_valid;
  end

  // Next-state logic: FSM, shift register, counters and output registers.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    lane_d  = lane_q;
    word_d  = word_q;
    di_d    = di_q;
    en_d    = 1'b0;
    init_d  = 1'b0;
    crci_d  = crci_q;
    crcv_d  = 1'b0;
    ferr_d  = ferr_q;

    // A start that arrives while a frame is running is flagged, but the running
    // frame is not disturbed.
    if (start && (state_q != IDLE)) begin
      ferr_d = 1'b1;
    end

    if (abort && (state_q != IDLE)) begin
      // Drop the frame. The packed word and captured CRC keep their last values.
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          // When abort and start arrive together, abort wins and the FSM stays here.
          if (start && !abort) begin
            state_d = INIT;
            init_d  = 1'b1;
            ferr_d  = 1'b0;
          end
        end
        INIT: begin
          lane_d  = 3'd0;
          word_d  = '0;
          state_d = DATA;
        end
        DATA: begin
          if (xfer) begin
            sr_d   = {sr_q[47:0], byte_in};
            lane_d = lane_q + 3'd1;
            if (lane_q == 3'd7) begin
              di_d   = {sr_q, byte_in};
              en_d   = 1'b1;
              word_d = word_q + WCW'(1);
              if (word_q == LAST_WORD) begin
                state_d = CRC_HI;
              end
            end
          end
        end
        CRC_HI: begin
          if (xfer) begin
            crci_d[15:8] = byte_in;
            state_d      = CRC_LO;
          end
        end
        CRC_LO: begin
          if (xfer) begin
            crci_d[7:0] = byte_in;
            crcv_d      = 1'b1;
            state_d     = DONE;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State registers, cleared asynchronously by the active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      lane_q  <= '0;
      word_q  <= '0;
      di_q    <= '0;
      en_q    <= 1'b0;
      init_q  <= 1'b0;
      crci_q  <= '0;
      crcv_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      lane_q  <= lane_d;
      word_q  <= word_d;
      di_q    <= di_d;
      en_q    <= en_d;
      init_q  <= init_d;
      crci_q  <= crci_d;
      crcv_q  <= crcv_d;
      ferr_q  <= ferr_d;
    end
  end

  // Output mapping.
  always_comb begin
    byte_ready   = ready;
    busy         = (state_q != IDLE);
    initialize   = init_q;
    crc16_enable = en_q;
    crc16_DI     = di_q;
    crc16_I      = crci_q;
    crc_valid    = crcv_q;
    frame_err    = ferr_q;
  end

endmodule
